// File: rtl/aes_inv_key_schedule_if.sv
// Round-key stream bundle for the inverse AES-128 key schedule.
// master = key consumer/requester, slave = the key schedule itself.
interface aes_inv_key_schedule_if #(
    parameter int WIDTH = 128
);
    logic             start_i;
    logic [WIDTH-1:0] key_i;
    logic [WIDTH-1:0] key_o;
    logic [3:0]       key_rnd_o;
    logic             key_vld_o;
    logic             ready_i;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, key_i, ready_i,
        input  key_o, key_rnd_o, key_vld_o, busy_o, done_o
    );

    modport slave (
        input  start_i, key_i, ready_i,
        output key_o, key_rnd_o, key_vld_o, busy_o, done_o
    );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// Iterative inverse AES-128 key schedule: streams round keys NR..0 from the round-NR key.
// Optional macro INV_KEY_SBOX_REG_EN adds a STEP state that registers the S-box output.
module aes_inv_key_schedule #(
    parameter int WIDTH = 128,
    parameter int NR    = 10
) (
    input logic                   clk_i,
    input logic                   rst_i,
    aes_inv_key_schedule_if.slave bus
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1
`ifdef INV_KEY_SBOX_REG_EN
        ,
        STEP = 2'd2
`endif
    } state_t;

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
    endfunction

    // Divide by x in GF(2^8): walks rcon backwards, 36 -> 1B -> 80 -> ... -> 01.
    function automatic logic [7:0] inv_xtime(input logic [7:0] r);
        logic [8:0] t;
        t = r[0] ? ({1'b0, r} ^ 9'h11B) : {1'b0, r};
        return t[8:1];
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       rcon;
    logic [7:0]       rcon_nxt;
    logic [WIDTH-1:0] key_nxt;
    logic [3:0]       rnd_nxt;
    logic             vld_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [31:0] a0, a1, a2, a3;
    logic [31:0] b1, b2, b3;
    logic        accept;
    logic        last;

    assign a0     = bus.key_o[127:96];
    assign a1     = bus.key_o[95:64];
    assign a2     = bus.key_o[63:32];
    assign a3     = bus.key_o[31:0];
    assign b1     = a1 ^ a0;
    assign b2     = a2 ^ a1;
    assign b3     = a3 ^ a2;
    assign accept = bus.key_vld_o & bus.ready_i;
    assign last   = (bus.key_rnd_o == 4'd0);

`ifdef INV_KEY_SBOX_REG_EN
    logic [31:0] sub_p0;
    logic [31:0] b1_p0, b2_p0, b3_p0;

    // S-box result and xor words captured on acceptance; STEP finishes the round key from them.
    always_ff @(posedge clk_i) begin
        if (state == EMIT && accept && !last) begin
            sub_p0 <= sub_rot(b3);
            b1_p0  <= b1;
            b2_p0  <= b2;
            b3_p0  <= b3;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        key_nxt   = bus.key_o;
        rnd_nxt   = bus.key_rnd_o;
        rcon_nxt  = rcon;
        vld_nxt   = bus.key_vld_o;
        busy_nxt  = bus.busy_o;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    state_nxt = EMIT;
                    key_nxt   = bus.key_i;
                    rnd_nxt   = 4'(NR);
                    rcon_nxt  = 8'h36;
                    vld_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            EMIT: begin
                if (accept) begin
                    if (last) begin
                        state_nxt = IDLE;
                        vld_nxt   = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
`ifdef INV_KEY_SBOX_REG_EN
                        state_nxt = STEP;
                        vld_nxt   = 1'b0;
`else
                        key_nxt   = {a0 ^ sub_rot(b3) ^ {rcon, 24'h0}, b1, b2, b3};
                        rnd_nxt   = bus.key_rnd_o - 4'd1;
                        rcon_nxt  = inv_xtime(rcon);
`endif
                    end
                end
            end
`ifdef INV_KEY_SBOX_REG_EN
            STEP: begin
                state_nxt = EMIT;
                vld_nxt   = 1'b1;
                key_nxt   = {a0 ^ sub_p0 ^ {rcon, 24'h0}, b1_p0, b2_p0, b3_p0};
                rnd_nxt   = bus.key_rnd_o - 4'd1;
                rcon_nxt  = inv_xtime(rcon);
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            rcon          <= 8'h00;
            bus.key_o     <= '0;
            bus.key_rnd_o <= 4'd0;
            bus.key_vld_o <= 1'b0;
            bus.busy_o    <= 1'b0;
            bus.done_o    <= 1'b0;
        end else begin
            state         <= state_nxt;
            rcon          <= rcon_nxt;
            bus.key_o     <= key_nxt;
            bus.key_rnd_o <= rnd_nxt;
            bus.key_vld_o <= vld_nxt;
            bus.busy_o    <= busy_nxt;
            bus.done_o    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Scoreboard bench for aes_inv_key_schedule; reference model rebuilds the whole
// 44-word expanded key backwards from the round-10 key.
`timescale 1ns/1ps
module tb_aes_inv_key_schedule;
    localparam int NR = 10;
`ifdef INV_KEY_SBOX_REG_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 1;
`endif
    localparam int DONE_LAT = 1 + NR * GAP + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_inv_key_schedule_if #(.WIDTH(128)) bus ();
    aes_inv_key_schedule #(.WIDTH(128), .NR(NR)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        mon_e;
    logic [7:0]   sbox [256];
    logic [127:0] got [0:NR];
    int errors = 0, checks = 0;
    int ncyc = 0, start_cyc = 0, r10_cyc = 0, done_cyc = 0, beats = 0, dones = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_key = '0;
    logic [3:0]   prev_rnd = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name, input int budget);
        checks++;
        errors++;
        $display("FAIL %s: actual=not reached required=reached within %0d cycles", name, budget);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int j = 1; j < 256; j++)
                if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // KeyExpansion recurrence w[i] = w[i-4] ^ temp(w[i-1]) solved for w[i-4], i = 43 down to 4.
    task automatic build_expected(input logic [127:0] k10);
        logic [31:0] w [44];
        logic [7:0]  rc [11];
        logic [31:0] t;
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int r = 2; r <= 10; r++) rc[r] = gmul(rc[r-1], 8'h02);
        for (int j = 0; j < 4; j++) w[40+j] = k10[127 - 32*j -: 32];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {rc[i/4], 24'h0};
            w[i-4] = w[i] ^ t;
        end
        for (int r = 10; r >= 0; r--)
            exp_q.push_back('{rnd: 4'(r), key: {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}});
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.start_i && !bus.busy_o) start_cyc = ncyc;
            if (prev_stall) begin
                check("hold_key", bus.key_o, prev_key);
                check("hold_rnd", 128'(bus.key_rnd_o), 128'(prev_rnd));
            end
            if (bus.key_vld_o && bus.ready_i) begin
                beats++;
                if (bus.key_rnd_o == 4'(NR)) r10_cyc = ncyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: actual=round %0d required=no beat", bus.key_rnd_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_rnd", 128'(bus.key_rnd_o), 128'(mon_e.rnd));
                    check("beat_key", bus.key_o, mon_e.key);
                end
                if (bus.key_rnd_o <= 4'(NR)) got[bus.key_rnd_o] = bus.key_o;
            end
            if (bus.done_o) begin
                dones++;
                done_cyc = ncyc;
            end
            prev_stall = bus.key_vld_o && !bus.ready_i;
            prev_key   = bus.key_o;
            prev_rnd   = bus.key_rnd_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [127:0] k);
        bus.start_i = 1'b1;
        bus.key_i   = k;
        tick();
        bus.start_i = 1'b0;
    endtask

    // Returns at the start of the done_o cycle.
    task automatic wait_done(input string name, input int budget, input bit rand_ready);
        int n;
        for (n = 0; n < budget; n++) begin
            if (rand_ready) bus.ready_i = 1'($urandom_range(0, 1));
            tick();
            if (bus.done_o) break;
        end
        if (n >= budget) fail_timeout(name, budget);
        bus.ready_i = 1'b1;
    endtask

    task automatic wait_beats(input string name, input int target, input int budget);
        int n;
        for (n = 0; n < budget && beats < target; n++) tick();
        if (beats < target) fail_timeout(name, budget);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_key"},  bus.key_o, 128'h0);
        check({tag, "_rnd"},  128'(bus.key_rnd_o), 128'h0);
        check({tag, "_vld"},  128'(bus.key_vld_o), 128'h0);
        check({tag, "_busy"}, 128'(bus.busy_o), 128'h0);
        check({tag, "_done"}, 128'(bus.done_o), 128'h0);
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, b0;
        logic [127:0] k;
        build_sbox();
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.key_i   = '0;
        bus.ready_i = 1'b0;
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // FIPS-197 vector with ready held high
        bus.ready_i = 1'b1;
        d0 = dones;
        build_expected(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        start_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_done("fips_done", 100, 1'b0);
        tick();
        check("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips_r9",  got[9],  128'hac7766f319fadc2128d12941575c006e);
        check("fips_r1",  got[1],  128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_r0",  got[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("fips_first_lat", 128'(r10_cyc - start_cyc), 128'(1));
        check("fips_done_lat", 128'(done_cyc - start_cyc), 128'(DONE_LAT));
        check("fips_done_cnt", 128'(dones - d0), 128'(1));
        check("fips_q_empty", 128'(exp_q.size()), 128'(0));
        check("fips_busy_end", 128'(bus.busy_o), 128'(0));

        // Random keys under random backpressure
        for (int t = 0; t < 4; t++) begin
            k = rand_key();
            d0 = dones;
            build_expected(k);
            start_seq(k);
            wait_done("bp_done", 400, 1'b1);
            tick();
            check("bp_done_cnt", 128'(dones - d0), 128'(1));
            check("bp_q_empty", 128'(exp_q.size()), 128'(0));
        end

        // Start pulse while busy must be ignored
        k = rand_key();
        d0 = dones;
        b0 = beats;
        build_expected(k);
        start_seq(k);
        wait_beats("busy_beats", b0 + 5, 100);
        bus.start_i = 1'b1;
        bus.key_i   = ~k;
        tick();
        bus.start_i = 1'b0;
        wait_done("busy_done", 100, 1'b0);
        tick();
        check("busy_done_lat", 128'(done_cyc - start_cyc), 128'(DONE_LAT));
        check("busy_done_cnt", 128'(dones - d0), 128'(1));
        check("busy_q_empty", 128'(exp_q.size()), 128'(0));

        // Asynchronous reset after round 6 has been emitted
        k = rand_key();
        b0 = beats;
        build_expected(k);
        start_seq(k);
        wait_beats("rst_beats", b0 + 5, 100);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        k = rand_key();
        d0 = dones;
        build_expected(k);
        start_seq(k);
        wait_done("rst_done", 100, 1'b0);
        tick();
        check("rst_first_lat", 128'(r10_cyc - start_cyc), 128'(1));
        check("rst_done_lat", 128'(done_cyc - start_cyc), 128'(DONE_LAT));
        check("rst_done_cnt", 128'(dones - d0), 128'(1));
        check("rst_q_empty", 128'(exp_q.size()), 128'(0));

        // Back-to-back: new start in the done_o cycle with an all-zero round-10 key
        k = rand_key();
        d0 = dones;
        build_expected(k);
        start_seq(k);
        wait_done("b2b_done1", 100, 1'b0);
        check("b2b_done_seen", 128'(bus.done_o), 128'(1));
        build_expected(128'h0);
        bus.start_i = 1'b1;
        bus.key_i   = 128'h0;
        tick();
        bus.start_i = 1'b0;
        check("b2b_rnd", 128'(bus.key_rnd_o), 128'(10));
        check("b2b_key", bus.key_o, 128'h0);
        check("b2b_vld", 128'(bus.key_vld_o), 128'(1));
        wait_done("b2b_done2", 100, 1'b0);
        tick();
        check("b2b_first_lat", 128'(r10_cyc - start_cyc), 128'(1));
        check("b2b_done_lat", 128'(done_cyc - start_cyc), 128'(DONE_LAT));
        check("b2b_done_cnt", 128'(dones - d0), 128'(2));
        check("b2b_q_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
Iterative inverse AES-128 key schedule for the decryption datapath. Accepts the round-10 key and walks the schedule backwards, computing one round key per step. It streams round keys 10, 9, ..., 0 over a valid/ready interface, in the order the inverse cipher consumes them. It is the reverse-direction counterpart of the forward KeyExpansion block and reuses the same S-box and word layout: word 0 = bits [127:96].

Parameters:
- WIDTH, 128, key width; only 128 is supported.
- NR, 10, number of rounds; the round counter starts here.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  one-cycle request; samples key_i; ignored while busy_o=1.
- key_i  input  WIDTH  round-NR key, i.e. the last forward round key.
- key_o  output  WIDTH  current round key; registered.
- key_rnd_o  output  4  round index of key_o, NR down to 0.
- key_vld_o  output  1  key_o/key_rnd_o valid.
- ready_i  input  1  consumer accepts the beat when key_vld_o & ready_i.
- busy_o  output  1  high from the cycle after start until after the final beat.
- done_o  output  1  one-cycle pulse on the cycle after the round-0 beat is accepted.

Behaviour:
- Reset (async, any time, including mid-sequence): state=IDLE; key_o=0, key_rnd_o=0, key_vld_o=0, busy_o=0, done_o=0; internal rcon=0.
- States:
  - IDLE, EMIT, plus STEP when INV_KEY_SBOX_REG_EN is defined.
  - IDLE: on start_i, load key_o=key_i, key_rnd_o=NR, rcon=8'h36. Next cycle: EMIT, key_vld_o=1, busy_o=1.
  - EMIT, no acceptance (key_vld_o=1 & ready_i=0): key_o and key_rnd_o hold stable.
  - EMIT, accepted, key_rnd_o=0: next cycle IDLE, key_vld_o=0, busy_o=0, done_o=1 for one cycle; key_o retains the round-0 key.
  - EMIT, accepted, key_rnd_o!=0: next cycle key_o = previous round key, key_rnd_o-1, rcon=inv_xtime(rcon); remain in EMIT.
- Inverse round step, given K=(a0,a1,a2,a3):
  - b3=a3^a2, b2=a2^a1, b1=a1^a0.
  - b0 = a0 ^ SubWord(RotWord(b3)) ^ {rcon,24'h0}.
- inv_xtime(r): if r[0] then (r^9'h11B)>>1, else r>>1. Sequence: 36,1B,80,40,20,10,08,04,02,01.
- Throughput/latency: with ready_i held high, beats occur on cycles 1..11 after start (cycle 0); done_o pulses on cycle 12.
- start_i asserted while busy_o=1 is ignored; no queuing.
- start_i asserted in the same cycle done_o is high is accepted, since the FSM is already in IDLE.
- ready_i while key_vld_o=0 has no effect.
- Behaviour is fully combinational-free on outputs: all outputs come straight from flops.

Optional Feature:
Macro INV_KEY_SBOX_REG_EN.
- Defined: on acceptance with key_rnd_o!=0, the FSM enters STEP for one cycle. In STEP it registers SubWord(RotWord(b3)) and the b1..b3 words, with key_vld_o=0. It then returns to EMIT with the new key. This cuts the S-box out of the EMIT-to-key_o path.
- Defined, timing: beats occur every 2 cycles with ready high (cycles 1,3,...,21); done_o pulses on cycle 22.
- Undefined: STEP does not exist; one beat per cycle.

Test Plan:
- Full sequence, FIPS-197 key: key_i=d014f9a8c9ee2589e13f0cc8b6630ca6, ready_i=1. Expect:
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - round 9 = ac7766f319fadc2128d12941575c006e
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c
  - done_o on cycle 12 (cycle 22 with the macro defined).
- Backpressure: random ready_i, low 50% of cycles. Expect key_o/key_rnd_o stable while valid & !ready, the same 11 keys in order with no drops or duplicates, and exactly one done_o.
- Start while busy: pulse start_i with a different key at beat 5. Expect the sequence unchanged and no restart.
- Reset mid-operation: assert rst_i asynchronously after round 6 is emitted. Expect all outputs 0 immediately. A fresh start then produces round 10 first again.
- Back-to-back: assert start_i in the done_o cycle with key_i=all-zero round-10 key. Expect a new sequence starting the next cycle with key_rnd_o=10 and key_o=0.
